// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, FSM states and strobe levels for the mul/div sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MTHI  = 3'd4,
    MD_OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE     = 2'd0,
    MD_MUL_WAIT = 2'd1,
    MD_DIV_RUN  = 2'd2,
    MD_DONE     = 2'd3
  } md_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic STOP                 = 1'b1;
  localparam logic NO_STOP              = 1'b0;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-side op/stall/HI-LO signals plus the multiplier and divider handshakes.
interface muldiv_ctrl_if;
  logic        op_valid_i;
  logic [2:0]  op_code_i;
  logic [31:0] src_a_i, src_b_i;
  logic        ex_hold_i, flush_i;
  logic        mul_start_o, mul_signed_o;
  logic [31:0] mul_a_o, mul_b_o;
  logic [63:0] mul_result_i;
  logic        div_start_o, div_signed_o, div_annul_o, div_ready_i;
  logic [31:0] div_a_o, div_b_o;
  logic [63:0] div_result_i;
  logic        stallreq_o;
  logic [31:0] hi_o, lo_o;

  modport slave (
    input  op_valid_i, op_code_i, src_a_i, src_b_i, ex_hold_i, flush_i,
           mul_result_i, div_result_i, div_ready_i,
    output mul_start_o, mul_signed_o, mul_a_o, mul_b_o,
           div_start_o, div_signed_o, div_a_o, div_b_o, div_annul_o,
           stallreq_o, hi_o, lo_o
  );

  modport master (
    output op_valid_i, op_code_i, src_a_i, src_b_i, ex_hold_i, flush_i,
           mul_result_i, div_result_i, div_ready_i,
    input  mul_start_o, mul_signed_o, mul_a_o, mul_b_o,
           div_start_o, div_signed_o, div_a_o, div_b_o, div_annul_o,
           stallreq_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl_hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module muldiv_ctrl_hilo_reg (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_d,
  input  logic [31:0] lo_d,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// Mul/div sequencer: drives multiplier/divider, stalls EX, owns HI/LO.
// Optional MULDIV_DIV0_BYPASS_EN: divide-by-zero completes at accept without the divider.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input logic          clk,
  input logic          resetn,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = $clog2(MUL_LAT + 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mul_a_q, mul_b_q, div_a_q, div_b_q;
  logic          mul_sgn_q, div_sgn_q;
  logic          accept, div0, mul_done, div_rdy;
  logic          hi_we, lo_we;
  logic [31:0]   hi_d, lo_d, hi_q, lo_q;
  logic          stall, mul_start, div_start, div_annul;

  assign accept   = bus.op_valid_i && !bus.flush_i;
  assign mul_done = (cnt_q <= CW'(1));
  assign div_rdy  = (bus.div_ready_i == DIV_RESULT_READY);
`ifdef MULDIV_DIV0_BYPASS_EN
  assign div0 = (bus.src_b_i == 32'd0);
`else
  assign div0 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mul_a_q <= '0; mul_b_q <= '0; mul_sgn_q <= 1'b0;
      div_a_q <= '0; div_b_q <= '0; div_sgn_q <= 1'b0;
    end else if (state_q == MD_IDLE && accept) begin
      if (is_mul(bus.op_code_i)) begin
        mul_a_q   <= bus.src_a_i;
        mul_b_q   <= bus.src_b_i;
        mul_sgn_q <= (bus.op_code_i == MD_OP_MULT);
      end
      if (is_div(bus.op_code_i) && !div0) begin
        div_a_q   <= bus.src_a_i;
        div_b_q   <= bus.src_b_i;
        div_sgn_q <= (bus.op_code_i == MD_OP_DIV);
      end
    end
  end

  // Flush overrides every transition, including completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: if (accept) begin
        if (is_mul(bus.op_code_i)) begin
          state_d = MD_MUL_WAIT;
          cnt_d   = CW'(MUL_LAT);
        end else if (is_div(bus.op_code_i) && !div0) begin
          state_d = MD_DIV_RUN;
        end
      end
      MD_MUL_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (mul_done) state_d = bus.ex_hold_i ? MD_DONE : MD_IDLE;
      end
      MD_DIV_RUN: if (div_rdy) state_d = bus.ex_hold_i ? MD_DONE : MD_IDLE;
      MD_DONE:    if (!bus.ex_hold_i) state_d = MD_IDLE;
      default:    state_d = MD_IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    stall     = NO_STOP;
    mul_start = 1'b0;
    div_start = DIV_STOP;
    div_annul = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = '0;
    lo_d      = '0;
    case (state_q)
      MD_IDLE: if (accept) begin
        if (bus.op_code_i == MD_OP_MTHI) begin
          hi_we = 1'b1; hi_d = bus.src_a_i;
        end else if (bus.op_code_i == MD_OP_MTLO) begin
          lo_we = 1'b1; lo_d = bus.src_a_i;
        end else if (is_mul(bus.op_code_i)) begin
          stall = STOP;
        end else if (is_div(bus.op_code_i)) begin
          if (div0) begin
            hi_we = 1'b1; lo_we = 1'b1;
            hi_d  = bus.src_a_i; lo_d = 32'hFFFF_FFFF;
          end else begin
            stall = STOP;
          end
        end
      end
      MD_MUL_WAIT: begin
        mul_start = (cnt_q == CW'(MUL_LAT));
        if (!mul_done) stall = STOP;
        else if (!bus.flush_i) begin
          hi_we = 1'b1; lo_we = 1'b1;
          {hi_d, lo_d} = bus.mul_result_i;
        end
      end
      MD_DIV_RUN: begin
        div_annul = bus.flush_i;
        if (!div_rdy) begin
          stall     = STOP;
          div_start = bus.flush_i ? DIV_STOP : DIV_START;
        end else if (!bus.flush_i) begin
          hi_we = 1'b1; lo_we = 1'b1;
          {hi_d, lo_d} = bus.div_result_i;
        end
      end
      default: ;
    endcase
    // State is still stale in the reset cycle; keep every strobe quiet.
    if (!resetn) begin
      stall = NO_STOP; mul_start = 1'b0; div_start = DIV_STOP; div_annul = 1'b0;
      hi_we = 1'b0;    lo_we = 1'b0;
    end
  end

  muldiv_ctrl_hilo_reg u_hilo (
    .clk   (clk),
    .resetn(resetn),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi_d  (hi_d),
    .lo_d  (lo_d),
    .hi_q  (hi_q),
    .lo_q  (lo_q)
  );

  assign bus.mul_start_o  = mul_start;
  assign bus.mul_signed_o = mul_sgn_q;
  assign bus.mul_a_o      = mul_a_q;
  assign bus.mul_b_o      = mul_b_q;
  assign bus.div_start_o  = div_start;
  assign bus.div_signed_o = div_sgn_q;
  assign bus.div_a_o      = div_a_q;
  assign bus.div_b_o      = div_b_q;
  assign bus.div_annul_o  = div_annul;
  assign bus.stallreq_o   = stall;
  assign bus.hi_o         = hi_q;
  assign bus.lo_o         = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural multiplier/divider stubs plus a cycle-level HI/LO/stall model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  int          nvec = 0, nerr = 0;
  int          mstarts, dcnt;
  int          div_lat = 4;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  muldiv_ctrl_if bus();
  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    xa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    xb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return xa * xb;
  endfunction

  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
  endfunction

  // Functional stand-ins for the execution units.
  assign bus.mul_result_i = mul_ref(bus.mul_signed_o, bus.mul_a_o, bus.mul_b_o);
  assign bus.div_result_i = div_ref(bus.div_signed_o, bus.div_a_o, bus.div_b_o);
  assign bus.div_ready_i  = (dcnt == div_lat) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dcnt    <= 0;
      mstarts <= 0;
    end else begin
      dcnt <= bus.div_start_o ? dcnt + 1 : 0;
      if (bus.mul_start_o) mstarts <= mstarts + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.op_valid_i = 1'b0; bus.flush_i = 1'b0; bus.ex_hold_i = 1'b0;
    #1;
    chk("idle_stall", 64'(bus.stallreq_o), 64'(0));
    chk("idle_annul", 64'(bus.div_annul_o), 64'(0));
    chk("idle_dstart", 64'(bus.div_start_o), 64'(0));
    chk("idle_hi", 64'(bus.hi_o), 64'(exp_hi));
    chk("idle_lo", 64'(bus.lo_o), 64'(exp_lo));
    tick();
  endtask

  // One EX op: stall expected for MUL_LAT cycles (mult) or div_lat+1 (div),
  // HI/LO written at the end of the completing cycle unless flushed.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int flush_at);
    bit          mul, dv, lng, fl;
    int          n, ms0;
    logic [63:0] res;
    mul = (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    dv  = (op == MD_OP_DIV) || (op == MD_OP_DIVU);
`ifdef MULDIV_DIV0_BYPASS_EN
    lng = mul || (dv && b != 32'd0);
`else
    lng = mul || dv;
`endif
    n   = !lng ? 0 : (mul ? MUL_LAT : div_lat + 1);
    res = mul ? mul_ref(op == MD_OP_MULT, a, b) : div_ref(op == MD_OP_DIV, a, b);
    ms0 = mstarts;
    fl  = 1'b0;
    for (int k = 0; k <= n; k++) begin
      bus.op_valid_i = 1'b1; bus.op_code_i = op; bus.src_a_i = a; bus.src_b_i = b;
      bus.flush_i   = (k == flush_at);
      bus.ex_hold_i = (k == n) && (hold > 0);
      #1;
      chk("hi", 64'(bus.hi_o), 64'(exp_hi));
      chk("lo", 64'(bus.lo_o), 64'(exp_lo));
      chk("annul", 64'(bus.div_annul_o), 64'(dv && lng && k >= 1 && k == flush_at));
      if (k == flush_at) begin
        fl = 1'b1;
        tick();
        break;
      end
      chk("stall", 64'(bus.stallreq_o), 64'(k < n));
      if (dv) chk("div_start", 64'(bus.div_start_o), 64'(lng && k >= 1 && k < n));
      if (k == n) begin
        case (op)
          MD_OP_MTHI: exp_hi = a;
          MD_OP_MTLO: exp_lo = a;
          default:    {exp_hi, exp_lo} = res;
        endcase
      end
      tick();
    end
    if (!fl && hold > 0) begin
      for (int h = 1; h < hold; h++) begin
        bus.ex_hold_i = 1'b1; bus.flush_i = 1'b0;
        #1;
        chk("hold_stall", 64'(bus.stallreq_o), 64'(0));
        chk("hold_hi", 64'(bus.hi_o), 64'(exp_hi));
        chk("hold_lo", 64'(bus.lo_o), 64'(exp_lo));
        tick();
      end
      bus.op_valid_i = 1'b0; bus.ex_hold_i = 1'b0;
      #1;
      chk("release_stall", 64'(bus.stallreq_o), 64'(0));
      tick();
    end
    if (mul && !fl) chk("mul_starts", 64'(mstarts - ms0), 64'(1));
    bus.flush_i = 1'b0; bus.ex_hold_i = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          hold, fat;
    bus.op_valid_i = 1'b0; bus.op_code_i = '0; bus.src_a_i = '0; bus.src_b_i = '0;
    bus.ex_hold_i  = 1'b0; bus.flush_i = 1'b0;
    resetn = 1'b0;
    tick(); tick();
    chk("rst_hi", 64'(bus.hi_o), 64'(0));
    chk("rst_lo", 64'(bus.lo_o), 64'(0));
    chk("rst_stall", 64'(bus.stallreq_o), 64'(0));
    chk("rst_mstart", 64'(bus.mul_start_o), 64'(0));
    chk("rst_dstart", 64'(bus.div_start_o), 64'(0));
    chk("rst_annul", 64'(bus.div_annul_o), 64'(0));
    chk("rst_mul_a", 64'(bus.mul_a_o), 64'(0));
    chk("rst_div_b", 64'(bus.div_b_o), 64'(0));
    resetn = 1'b1;
    idle();

    run_op(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, -1);
    #1;
    chk("tp_mult_hi", 64'(bus.hi_o), 64'(32'hFFFF_FFFF));
    chk("tp_mult_lo", 64'(bus.lo_o), 64'(32'hFFFF_FFFA));
    idle();

    div_lat = 33;
    run_op(MD_OP_DIVU, 32'd100, 32'd7, 0, -1);
    #1;
    chk("tp_divu_lo", 64'(bus.lo_o), 64'(14));
    chk("tp_divu_hi", 64'(bus.hi_o), 64'(2));
    idle();

    run_op(MD_OP_DIV, 32'd1000, 32'd3, 0, 10);
    idle();

    run_op(MD_OP_MULTU, 32'h8000_0001, 32'h10, 3, -1);
    idle();

    run_op(MD_OP_MTHI, 32'h1234_5678, 32'd0, 0, -1);
    run_op(MD_OP_MTLO, 32'd9, 32'd0, 0, -1);
    #1;
    chk("tp_mthi", 64'(bus.hi_o), 64'(32'h1234_5678));
    chk("tp_mtlo", 64'(bus.lo_o), 64'(9));
    idle();

    div_lat = 4;
    run_op(MD_OP_DIV, 32'd5, 32'd0, 0, -1);
    #1;
    chk("tp_div0_lo", 64'(bus.lo_o), 64'(32'hFFFF_FFFF));
    chk("tp_div0_hi", 64'(bus.hi_o), 64'(5));

    // Back-to-back ops with random operands, latency, hold and flush.
    for (int i = 0; i < 80; i++) begin
      op      = 3'($urandom_range(0, 5));
      a       = $urandom();
      b       = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 20));
      div_lat = $urandom_range(1, 6);
      hold    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      fat     = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
      run_op(op, a, b, hold, fat);
    end
    idle();

    // Reset in the middle of a divide.
    div_lat = 20;
    bus.op_valid_i = 1'b1; bus.op_code_i = MD_OP_DIVU; bus.src_a_i = 32'd50; bus.src_b_i = 32'd5;
    tick(); tick(); tick();
    resetn = 1'b0; bus.flush_i = 1'b1;
    #1;
    chk("rstmid_annul", 64'(bus.div_annul_o), 64'(0));
    chk("rstmid_stall", 64'(bus.stallreq_o), 64'(0));
    chk("rstmid_dstart", 64'(bus.div_start_o), 64'(0));
    tick();
    resetn = 1'b1; bus.flush_i = 1'b0; bus.op_valid_i = 1'b0;
    exp_hi = '0; exp_lo = '0;
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
